// File: rtl/driver_if_pkg.sv
// ============================================================================
//  Module  : driver_if_pkg
//  Purpose : Register map, bit indices and control struct for the TX bridge.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package driver_if_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_THRESH = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_FLUSH_BIT  = 2;

    localparam int STAT_EMPTY_BIT    = 0;
    localparam int STAT_FULL_BIT     = 1;
    localparam int STAT_OVERFLOW_BIT = 2;
    localparam int STAT_UNDERRUN_BIT = 3;
    localparam int STAT_IRQ_BIT      = 4;
    localparam int STAT_LEVEL_LSB    = 8;

    typedef struct packed {
        logic irq_en;
        logic enable;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/driver_tx_interface_sync_fifo.sv
// ============================================================================
//  Module  : sync_fifo
//  Purpose : DEPTH x DATA_SIZE FIFO with modulo-DEPTH pointers and a word count.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DATA_SIZE  = 28,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [DATA_SIZE-1:0]  wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_SIZE-1:0]  rd_data_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [DATA_SIZE-1:0]  mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  w_do_wr;
    logic                  w_do_rd;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o    = (count_q == (ADDR_WIDTH + 1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign w_do_wr   = wr_en_i & ~full_o & ~clr_i;
    assign w_do_rd   = rd_en_i & ~empty_o & ~clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (w_do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({w_do_wr, w_do_rd})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/driver_tx_interface.sv
// ============================================================================
//  Module  : driver_tx_interface
//  Purpose : Bus-to-stream audio bridge: CPU pushes samples, registered stage
//            drains them onto a valid/ready stream; flags and low-water IRQ.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module driver_tx_interface
    import driver_if_pkg::*;
#(
    parameter int DATA_SIZE  = 28,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LVL_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chipselect,
    input  logic [1:0]            address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    output logic                  sink_valid,
    output logic [DATA_SIZE-1:0]  sink_data,
    input  logic                  sink_ready,
    output logic                  irq
);

    ctrl_t                 ctrl_q, ctrl_d;
    logic [LVL_WIDTH-1:0]  thresh_q, thresh_d;
    logic                  overflow_q, overflow_d;
    logic                  underrun_q, underrun_d;
    logic                  irq_q, irq_d;
    logic                  sink_valid_q, sink_valid_d;
    logic [DATA_SIZE-1:0]  sink_data_q, sink_data_d;
    logic [31:0]           read_data_q, read_data_d;

    logic                  w_bus_wr, w_bus_rd;
    logic                  w_wr_data, w_wr_ctrl, w_wr_status, w_wr_thresh;
    logic                  w_flush, w_push, w_load, w_pop;
    logic [DATA_SIZE-1:0]  w_fifo_head;
    logic [ADDR_WIDTH:0]   w_fifo_count;
    logic                  w_fifo_full, w_fifo_empty;
    logic [LVL_WIDTH-1:0]  w_level;
    logic [31:0]           w_rd_mux;
    logic                  w_unused_wdata;

    assign w_bus_wr    = chipselect & write;
    assign w_bus_rd    = chipselect & read;
    assign w_wr_data   = w_bus_wr & (address == REG_DATA);
    assign w_wr_ctrl   = w_bus_wr & (address == REG_CTRL);
    assign w_wr_status = w_bus_wr & (address == REG_STATUS);
    assign w_wr_thresh = w_bus_wr & (address == REG_THRESH);
    assign w_flush     = w_wr_ctrl & write_data[CTRL_FLUSH_BIT];
    assign w_push      = w_wr_data & ~w_fifo_full;
    assign w_load      = ctrl_q.enable & ~w_fifo_empty & (~sink_valid_q | sink_ready);
    assign w_pop       = w_load & ~w_flush;
    assign w_level     = LVL_WIDTH'(w_fifo_count) + LVL_WIDTH'(sink_valid_q);
    assign w_unused_wdata = ^write_data;

    sync_fifo #(
        .DATA_SIZE  (DATA_SIZE),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .clr_i     (w_flush),
        .wr_en_i   (w_push),
        .wr_data_i (write_data[DATA_SIZE-1:0]),
        .rd_en_i   (w_pop),
        .rd_data_o (w_fifo_head),
        .count_o   (w_fifo_count),
        .full_o    (w_fifo_full),
        .empty_o   (w_fifo_empty)
    );

    always_comb begin
        w_rd_mux = '0;
        case (address)
            REG_CTRL: begin
                w_rd_mux[CTRL_ENABLE_BIT] = ctrl_q.enable;
                w_rd_mux[CTRL_IRQ_EN_BIT] = ctrl_q.irq_en;
            end
            REG_STATUS: begin
                w_rd_mux[STAT_EMPTY_BIT]    = (w_level == '0);
                w_rd_mux[STAT_FULL_BIT]     = w_fifo_full;
                w_rd_mux[STAT_OVERFLOW_BIT] = overflow_q;
                w_rd_mux[STAT_UNDERRUN_BIT] = underrun_q;
                w_rd_mux[STAT_IRQ_BIT]      = irq_q;
                w_rd_mux[STAT_LEVEL_LSB +: LVL_WIDTH] = w_level;
            end
            REG_THRESH: w_rd_mux[LVL_WIDTH-1:0] = thresh_q;
            default:    w_rd_mux = '0;
        endcase
    end

    always_comb begin
        ctrl_d       = ctrl_q;
        thresh_d     = thresh_q;
        overflow_d   = overflow_q;
        underrun_d   = underrun_q;
        sink_valid_d = sink_valid_q;
        sink_data_d  = sink_data_q;
        read_data_d  = w_bus_rd ? w_rd_mux : '0;
        irq_d        = ctrl_q.irq_en & ctrl_q.enable & (w_level <= thresh_q);

        if (w_wr_ctrl) begin
            ctrl_d.enable = write_data[CTRL_ENABLE_BIT];
            ctrl_d.irq_en = write_data[CTRL_IRQ_EN_BIT];
        end
        if (w_wr_thresh) thresh_d = write_data[LVL_WIDTH-1:0];

        // Clears first so a same-cycle set event is never lost.
        if (w_wr_status && write_data[STAT_OVERFLOW_BIT]) overflow_d = 1'b0;
        if (w_wr_status && write_data[STAT_UNDERRUN_BIT]) underrun_d = 1'b0;
        if (w_wr_data && w_fifo_full) overflow_d = 1'b1;
        if (ctrl_q.enable && sink_ready && !sink_valid_q && w_fifo_empty) underrun_d = 1'b1;

        if (w_pop) begin
            sink_valid_d = 1'b1;
            sink_data_d  = w_fifo_head;
        end else if (sink_ready) begin
            sink_valid_d = 1'b0;
        end

        if (w_flush) begin
            sink_valid_d = 1'b0;
            overflow_d   = 1'b0;
            underrun_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q       <= '0;
            thresh_q     <= '0;
            overflow_q   <= 1'b0;
            underrun_q   <= 1'b0;
            irq_q        <= 1'b0;
            sink_valid_q <= 1'b0;
            sink_data_q  <= '0;
            read_data_q  <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            thresh_q     <= thresh_d;
            overflow_q   <= overflow_d;
            underrun_q   <= underrun_d;
            irq_q        <= irq_d;
            sink_valid_q <= sink_valid_d;
            sink_data_q  <= sink_data_d;
            read_data_q  <= read_data_d;
        end
    end

    assign read_data  = read_data_q;
    assign sink_valid = sink_valid_q;
    assign sink_data  = sink_data_q;
    assign irq        = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_driver_tx_interface.sv
// ============================================================================
//  Module  : tb_driver_tx_interface
//  Purpose : Directed bench; bus reads and stream samples checked by a
//            queue-based scoreboard, timing points checked inline.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_driver_tx_interface;
    import driver_if_pkg::*;

    localparam int DATA_SIZE = 28;
    localparam int DEPTH     = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 chipselect = 1'b0;
    logic [1:0]           address = 2'd0;
    logic                 read = 1'b0;
    logic                 write = 1'b0;
    logic [31:0]          write_data = 32'd0;
    logic [31:0]          read_data;
    logic                 sink_valid;
    logic [DATA_SIZE-1:0] sink_data;
    logic                 sink_ready = 1'b0;
    logic                 irq;

    int checks = 0;
    int failures = 0;

    logic [DATA_SIZE-1:0] exp_stream[$];
    logic [31:0]          exp_read[$];
    string                exp_rname[$];
    logic                 rd_pend = 1'b0;
    logic [5:0]           irq_pat;

    driver_tx_interface #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .address    (address),
        .read       (read),
        .write      (write),
        .write_data (write_data),
        .read_data  (read_data),
        .sink_valid (sink_valid),
        .sink_data  (sink_data),
        .sink_ready (sink_ready),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_read.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL bus_read: response 0x%08h with no expectation", read_data);
            end else begin
                check(exp_rname.pop_front(), read_data, exp_read.pop_front());
            end
        end
        rd_pend <= reset && chipselect && read;
        if (reset && sink_valid && sink_ready) begin
            if (exp_stream.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stream: unexpected sample 0x%07h expected none", sink_data);
            end else begin
                check("stream_sample", 32'(sink_data), 32'(exp_stream.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; write_data = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string n);
        exp_read.push_back(e);
        exp_rname.push_back(n);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("reset_sink_valid", 32'(sink_valid), 32'h0);
        check("reset_sink_data", 32'(sink_data), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_read_data", read_data, 32'h0);
        reset = 1'b1;
        tick();
        bus_read(REG_STATUS, 32'h0000_0001, "reset_status");
        bus_read(REG_CTRL,   32'h0, "reset_ctrl");
        bus_read(REG_THRESH, 32'h0, "reset_thresh");

        // 1: single sample latency
        bus_write(REG_CTRL, 32'h1);
        sink_ready = 1'b1;
        exp_stream.push_back(28'h0ABCDEF);
        bus_write(REG_DATA, 32'h0ABCDEF);
        check("t1_valid_edge1", 32'(sink_valid), 32'h0);
        tick();
        check("t1_valid_edge2", 32'(sink_valid), 32'h1);
        check("t1_data_edge2", 32'(sink_data), 32'h0ABCDEF);
        tick();
        check("t1_valid_edge3", 32'(sink_valid), 32'h0);

        // 2: backpressure hold then back-to-back drain
        sink_ready = 1'b0;
        bus_write(REG_CTRL, 32'h4);
        for (int i = 1; i <= 4; i++) begin
            exp_stream.push_back(DATA_SIZE'(i));
            bus_write(REG_DATA, 32'(i));
        end
        bus_write(REG_CTRL, 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_hold_valid", 32'(sink_valid), 32'h1);
            check("t2_hold_data", 32'(sink_data), 32'h1);
        end
        sink_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            tick();
            check("t2_b2b_valid", 32'(sink_valid), 32'h1);
            check("t2_b2b_data", 32'(sink_data), 32'(k));
        end
        tick();
        check("t2_drained_valid", 32'(sink_valid), 32'h0);
        sink_ready = 1'b0;
        check("t2_stream_queue", 32'(exp_stream.size()), 32'h0);

        // 3: overflow and full
        bus_write(REG_CTRL, 32'h4);
        for (int i = 0; i < DEPTH + 2; i++) bus_write(REG_DATA, 32'h100 + 32'(i));
        bus_read(REG_STATUS, 32'h0000_1006, "t3_status_full_ovf");
        bus_write(REG_STATUS, 32'h4);
        bus_read(REG_STATUS, 32'h0000_1002, "t3_status_ovf_clr");

        // 4: underrun sticky until W1C
        sink_ready = 1'b1;
        bus_write(REG_CTRL, 32'h5);
        tick();
        bus_read(REG_STATUS, 32'h0000_0009, "t4_underrun_set");
        exp_stream.push_back(28'h55);
        bus_write(REG_DATA, 32'h55);
        tick();
        tick();
        sink_ready = 1'b0;
        bus_read(REG_STATUS, 32'h0000_0009, "t4_underrun_sticky");
        bus_write(REG_STATUS, 32'h8);
        bus_read(REG_STATUS, 32'h0000_0001, "t4_underrun_clr");

        // 5: low-water irq
        bus_write(REG_CTRL, 32'h6);
        bus_write(REG_THRESH, 32'h2);
        for (int i = 0; i < 5; i++) begin
            exp_stream.push_back(DATA_SIZE'(32'h200 + 32'(i)));
            bus_write(REG_DATA, 32'h200 + 32'(i));
        end
        sink_ready = 1'b1;
        bus_write(REG_CTRL, 32'h3);
        irq_pat = 6'b110000;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t5_irq_drain", 32'(irq), 32'(irq_pat[k]));
        end
        sink_ready = 1'b0;
        bus_write(REG_THRESH, 32'h0);
        bus_write(REG_DATA, 32'h2FF);
        check("t5_irq_thresh0_lvl0", 32'(irq), 32'h1);
        tick();
        check("t5_irq_thresh0_lvl1", 32'(irq), 32'h0);

        // 6: flush with queued data, then async reset mid-stream
        bus_write(REG_CTRL, 32'h5);
        for (int i = 0; i < 6; i++) bus_write(REG_DATA, 32'h300 + 32'(i));
        tick();
        bus_read(REG_STATUS, 32'h0000_0600, "t6_level6");
        bus_write(REG_CTRL, 32'h5);
        check("t6_flush_valid", 32'(sink_valid), 32'h0);
        bus_read(REG_STATUS, 32'h0000_0001, "t6_after_flush");

        bus_write(REG_THRESH, 32'h8);
        bus_write(REG_CTRL, 32'h3);
        for (int i = 0; i < 3; i++) bus_write(REG_DATA, 32'h400 + 32'(i));
        tick();
        tick();
        check("t6_pre_reset_valid", 32'(sink_valid), 32'h1);
        check("t6_pre_reset_irq", 32'(irq), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("t6_reset_valid", 32'(sink_valid), 32'h0);
        check("t6_reset_data", 32'(sink_data), 32'h0);
        check("t6_reset_irq", 32'(irq), 32'h0);
        check("t6_reset_read_data", read_data, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        bus_read(REG_STATUS, 32'h0000_0001, "post_reset_status");
        bus_read(REG_CTRL,   32'h0, "post_reset_ctrl");
        bus_read(REG_THRESH, 32'h0, "post_reset_thresh");

        // Simultaneous write+read returns the pre-write value
        exp_read.push_back(32'h0);
        exp_rname.push_back("rw_same_cycle_pre");
        chipselect = 1'b1; write = 1'b1; read = 1'b1; address = REG_THRESH; write_data = 32'h5;
        tick();
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        bus_read(REG_THRESH, 32'h5, "rw_same_cycle_post");
        bus_write(REG_CTRL, 32'h7);
        bus_read(REG_CTRL, 32'h3, "ctrl_flush_reads0");
        bus_read(REG_DATA, 32'h0, "data_reads0");

        tick();
        tick();
        check("final_stream_queue", 32'(exp_stream.size()), 32'h0);
        check("final_read_queue", 32'(exp_read.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
